aes192_wb_master: RTL and testbench

AES192_WB_MASTER -- requirements
Module: aes192_wb_master

---
 rtl/aes192_wb_master_if.sv | 30 +++
 rtl/aes192_wb_master.sv | 183 ++++++++++++++++++
 tb/tb_aes192_wb_master.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes192_wb_master_if.sv
// aes192_wb_master_if: user request/response and Wishbone master signal bundle
interface aes192_wb_master_if;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_pt;
  logic [191:0] req_key;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_ct;
  logic         rsp_err;
  logic [31:0]  wb_adr_o;
  logic [31:0]  wb_dat_o;
  logic [3:0]   wb_sel_o;
  logic         wb_we_o;
  logic         wb_stb_o;
  logic         wb_cyc_o;
  logic [31:0]  wb_dat_i;
  logic         wb_ack_i;
  logic         wb_err_i;
  modport master (
    input  req_valid, req_pt, req_key, rsp_ready, wb_dat_i, wb_ack_i, wb_err_i,
    output req_ready, rsp_valid, rsp_ct, rsp_err,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o
  );
  modport slave (
    output req_valid, req_pt, req_key, rsp_ready, wb_dat_i, wb_ack_i, wb_err_i,
    input  req_ready, rsp_valid, rsp_ct, rsp_err,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/aes192_wb_master.sv
// aes192_wb_master: drives an AES-192 Wishbone slave per request; optional key cache via AES192_WB_MASTER_KEY_CACHE_EN
module aes192_wb_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          POLL_DELAY  = 4,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          POLL_LIMIT  = 1024
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  aes192_wb_master_if.master bus
);
  localparam int DW = $clog2(POLL_DELAY + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  typedef enum logic [2:0] {IDLE, WR_PT, WR_KEY, START, WAIT, POLL, RD_CT, RESP} state_t;
  state_t state, state_n;
  logic stb, stb_n, we, we_n, err, err_n, fail, hit, active, xwe;
  logic [31:0] adr, adr_n, dat, dat_n, xadr, xdat;
  logic [2:0] cnt, cnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [PW-1:0] polls, polls_n;
  logic [DW-1:0] dly, dly_n;
  logic [127:0] pt, pt_n, ct, ct_n;
  logic [191:0] key, key_n;
  assign active = state inside {WR_PT, WR_KEY, START, POLL, RD_CT};
  assign xwe = state inside {WR_PT, WR_KEY, START};
  assign xadr = BASE_ADDR + (state == WR_PT  ? 32'h04 + {27'd0, cnt, 2'b00} :
                             state == WR_KEY ? 32'h14 + {27'd0, cnt, 2'b00} :
                             state == POLL   ? 32'h2C :
                             state == RD_CT  ? 32'h30 + {27'd0, cnt, 2'b00} : 32'h0);
  assign xdat = state == WR_PT  ? pt[{cnt[1:0], 5'd0} +: 32] :
                state == WR_KEY ? key[{cnt, 5'd0} +: 32] :
                state == START  ? 32'h1 : 32'h0;
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_ct = ct;
  assign bus.rsp_err = err;
  assign bus.wb_adr_o = adr;
  assign bus.wb_dat_o = dat;
  assign bus.wb_we_o = we;
  assign bus.wb_stb_o = stb;
  assign bus.wb_cyc_o = stb;
  assign bus.wb_sel_o = {4{stb}};
  always_comb begin
    state_n = state;
    stb_n = stb;
    adr_n = adr;
    dat_n = dat;
    we_n = we;
    cnt_n = cnt;
    tmo_n = tmo;
    polls_n = polls;
    dly_n = dly;
    pt_n = pt;
    key_n = key;
    ct_n = ct;
    err_n = err;
    fail = 1'b0;
    if (state == IDLE && bus.req_valid) begin
      state_n = WR_PT;
      pt_n = bus.req_pt;
      key_n = bus.req_key;
      ct_n = '0;
      cnt_n = '0;
      polls_n = '0;
    end
    // the first poll is launched straight out of WAIT so the idle gap is exactly POLL_DELAY
    if (state == WAIT) begin
      dly_n = dly + 1'b1;
      if (dly == DW'(POLL_DELAY - 1)) begin
        state_n = POLL;
        stb_n = 1'b1;
        adr_n = BASE_ADDR + 32'h2C;
        tmo_n = '0;
      end
    end
    if (state == RESP && bus.rsp_ready) state_n = IDLE;
    if (active && !stb) begin
      stb_n = 1'b1;
      adr_n = xadr;
      dat_n = xdat;
      we_n = xwe;
      tmo_n = '0;
    end
    if (active && stb) begin
      if (bus.wb_ack_i || bus.wb_err_i) begin
        stb_n = 1'b0;
        adr_n = '0;
        dat_n = '0;
        we_n = 1'b0;
      end
      if (bus.wb_err_i || (!bus.wb_ack_i && tmo == TW'(ACK_TIMEOUT - 1))) fail = 1'b1;
      else if (!bus.wb_ack_i) tmo_n = tmo + 1'b1;
      else begin
        cnt_n = cnt + 3'd1;
        case (state)
          WR_PT: if (cnt == 3'd3) begin
            cnt_n = '0;
            state_n = hit ? START : WR_KEY;
          end
          WR_KEY: if (cnt == 3'd5) begin
            cnt_n = '0;
            state_n = START;
          end
          START: begin
            state_n = WAIT;
            dly_n = '0;
          end
          POLL: begin
            cnt_n = '0;
            polls_n = polls + 1'b1;
            state_n = bus.wb_dat_i[0] ? RD_CT : POLL;
            fail = !bus.wb_dat_i[0] && polls == PW'(POLL_LIMIT - 1);
          end
          RD_CT: begin
            ct_n[{2'd3 - cnt[1:0], 5'd0} +: 32] = bus.wb_dat_i;
            if (cnt == 3'd3) begin
              cnt_n = '0;
              state_n = RESP;
              err_n = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
    if (fail) begin
      state_n = RESP;
      err_n = 1'b1;
      ct_n = '0;
      stb_n = 1'b0;
      adr_n = '0;
      dat_n = '0;
      we_n = 1'b0;
      cnt_n = '0;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      stb <= 1'b0;
      adr <= '0;
      dat <= '0;
      we <= 1'b0;
      cnt <= '0;
      tmo <= '0;
      polls <= '0;
      dly <= '0;
      pt <= '0;
      key <= '0;
      ct <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      stb <= stb_n;
      adr <= adr_n;
      dat <= dat_n;
      we <= we_n;
      cnt <= cnt_n;
      tmo <= tmo_n;
      polls <= polls_n;
      dly <= dly_n;
      pt <= pt_n;
      key <= key_n;
      ct <= ct_n;
      err <= err_n;
    end
  end
`ifdef AES192_WB_MASTER_KEY_CACHE_EN
  logic [191:0] cache;
  logic cvld;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || fail) cvld <= 1'b0;
    else if (state == WR_KEY && stb && bus.wb_ack_i && cnt == 3'd5) begin
      cvld <= 1'b1;
      cache <= key;
    end
  end
  assign hit = cvld && cache == key;
`else
  assign hit = 1'b0;
`endif
endmodule

// File: tb/tb_aes192_wb_master.sv
// tb_aes192_wb_master: randomized directed bench with a register-level slave and transaction-list reference model
module tb_aes192_wb_master;
  localparam logic [31:0] BA = 32'h4000_0100;
  localparam int PL = 8;
  localparam int AT = 16;
  localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [191:0] FKEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] FCT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
`ifdef AES192_WB_MASTER_KEY_CACHE_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  aes192_wb_master_if bus();
  aes192_wb_master #(.BASE_ADDR(BA), .POLL_DELAY(4), .ACK_TIMEOUT(AT), .POLL_LIMIT(PL)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus)
  );
  int total = 0;
  int bad = 0;
  logic mute = 1'b0;
  logic err18 = 1'b0;
  logic s_e;
  int ready_at = 0;
  int poll_base = 0;
  int polls_seen = 0;
  logic [127:0] sct = '0;
  logic [31:0] off;
  logic [64:0] log_q[$];
  bit m_cvld = 0;
  logic [191:0] m_cache = '0;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // slave: ack one cycle after strobe, optional error on the 0x18 write, optional silence
  always @(posedge clk) begin
    if (bus.wb_stb_o && (bus.wb_ack_i || bus.wb_err_i)) begin
      log_q.push_back({bus.wb_adr_o, bus.wb_we_o, bus.wb_dat_o});
      if (bus.wb_ack_i && !bus.wb_we_o && bus.wb_adr_o == BA + 32'h2C) polls_seen <= polls_seen + 1;
    end
    s_e = err18 && bus.wb_we_o && bus.wb_adr_o == BA + 32'h18;
    bus.wb_ack_i <= bus.wb_stb_o && !bus.wb_ack_i && !bus.wb_err_i && !mute && !s_e;
    bus.wb_err_i <= bus.wb_stb_o && !bus.wb_ack_i && !bus.wb_err_i && s_e;
  end

  // read data is garbage (bit0 set) outside ack cycles
  always_comb begin
    off = bus.wb_adr_o - BA;
    bus.wb_dat_i = 32'hA5A5_A5A5;
    if (bus.wb_ack_i && off == 32'h2C) bus.wb_dat_i = {31'd0, (polls_seen - poll_base) >= ready_at};
    else if (bus.wb_ack_i && off >= 32'h30 && off <= 32'h3C)
      bus.wb_dat_i = sct[(3 - int'((off - 32'h30) >> 2)) * 32 +: 32];
  end

  logic p_stb = 1'b0, p_done = 1'b0, p_we = 1'b0;
  logic [31:0] p_adr = '0, p_dat = '0;
  always @(negedge clk) begin
    chk("cyc_eq_stb", bus.wb_cyc_o, bus.wb_stb_o);
    chk("sel", bus.wb_sel_o, bus.wb_stb_o ? 4'hF : 4'h0);
    if (bus.wb_stb_o && p_stb && !p_done)
      chk("hold", {bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o}, {p_adr, p_dat, p_we});
    if (p_done) chk("gap", bus.wb_stb_o, 1'b0);
    if (!bus.wb_stb_o) chk("idle_zero", {bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o}, 65'd0);
    p_stb = bus.wb_stb_o;
    p_done = bus.wb_stb_o && (bus.wb_ack_i || bus.wb_err_i);
    p_adr = bus.wb_adr_o;
    p_dat = bus.wb_dat_o;
    p_we = bus.wb_we_o;
  end

  task automatic send(input logic [127:0] p, input logic [191:0] k);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_pt = p;
    bus.req_key = k;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_pt = {$urandom, $urandom, $urandom, $urandom};
    bus.req_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // mode: 0 normal, 1 error on 0x18 write, 2 status never ready, 3 slave silent
  task automatic do_op(input logic [127:0] p, input logic [191:0] k, input logic [127:0] c,
                       input int rdy, input int mode, input int hold,
                       output int wr, output int kw, output int sw);
    logic [64:0] exp_q[$];
    logic [64:0] ent;
    logic [127:0] s_ct;
    logic s_err;
    bit e, h;
    int n, lb, np;
    sct = c;
    ready_at = mode == 2 ? (1 << 20) : rdy;
    err18 = mode == 1;
    mute = mode == 3;
    poll_base = polls_seen;
    lb = log_q.size();
    send(p, k);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", bus.rsp_valid, 1'b1);
    h = CE != 0 && m_cvld && m_cache == k;
    e = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back({BA + 32'h4 + 32'(4 * i), 1'b1, p[32 * i +: 32]});
    if (!h) begin
      for (int i = 0; i < 6; i++) begin
        exp_q.push_back({BA + 32'h14 + 32'(4 * i), 1'b1, k[32 * i +: 32]});
        if (mode == 1 && i == 1) begin
          e = 1;
          break;
        end
      end
    end
    if (!e) begin
      exp_q.push_back({BA, 1'b1, 32'h1});
      np = mode == 2 ? PL : rdy + 1;
      for (int i = 0; i < np; i++) exp_q.push_back({BA + 32'h2C, 1'b0, 32'h0});
      if (mode == 2) e = 1;
      else for (int i = 0; i < 4; i++) exp_q.push_back({BA + 32'h30 + 32'(4 * i), 1'b0, 32'h0});
    end
    if (mode == 3) begin
      exp_q.delete();
      e = 1;
    end
    if (e) m_cvld = 0;
    else if (!h) begin
      m_cvld = 1;
      m_cache = k;
    end
    chk("rsp_err", bus.rsp_err, e);
    chk("rsp_ct", bus.rsp_ct, e ? 128'h0 : c);
    chk("xfer_count", log_q.size() - lb, exp_q.size());
    for (int i = 0; i < exp_q.size() && lb + i < log_q.size(); i++) begin
      ent = log_q[lb + i];
      if (!ent[32]) ent[31:0] = '0;
      chk("xfer", ent, exp_q[i]);
    end
    wr = 0;
    kw = 0;
    sw = 0;
    for (int i = lb; i < log_q.size(); i++) begin
      ent = log_q[i];
      if (ent[32]) begin
        wr++;
        if (ent[64:33] >= BA + 32'h14 && ent[64:33] <= BA + 32'h28) kw++;
        if (ent[64:33] == BA) sw++;
      end
    end
    s_ct = bus.rsp_ct;
    s_err = bus.rsp_err;
    repeat (hold) begin
      chk("hold_valid", bus.rsp_valid, 1'b1);
      chk("hold_ct", bus.rsp_ct, s_ct);
      chk("hold_err", bus.rsp_err, s_err);
      chk("hold_req_ready", bus.req_ready, 1'b0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("req_ready_after", bus.req_ready, 1'b1);
    chk("rsp_valid_after", bus.rsp_valid, 1'b0);
    err18 = 1'b0;
    mute = 1'b0;
  endtask

  initial begin
    int wr, kw, sw, n;
    bit seen;
    logic [191:0] k;
    logic [191:0] pk;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_pt = '0;
    bus.req_key = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_rsp_ct", bus.rsp_ct, 128'h0);
    chk("rst_stb", {bus.wb_stb_o, bus.wb_cyc_o, bus.wb_we_o, bus.wb_sel_o}, 7'd0);
    rst = 1'b0;
    @(negedge clk);
    do_op(FPT, FKEY, FCT, 2, 0, 0, wr, kw, sw);
    chk("fips_writes", wr, 11);
    do_op(FPT, FKEY, FCT, 0, 0, 0, wr, kw, sw);
    chk("repeat_writes", wr, CE != 0 ? 5 : 11);
    chk("repeat_keywr", kw, CE != 0 ? 0 : 6);
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_op({$urandom, $urandom, $urandom, $urandom}, k, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 10, wr, kw, sw);
    k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_op({$urandom, $urandom, $urandom, $urandom}, k, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 2, wr, kw, sw);
    chk("err_nostart", sw, 0);
    do_op({$urandom, $urandom, $urandom, $urandom}, FKEY, {$urandom, $urandom, $urandom, $urandom}, 0, 2, 0, wr, kw, sw);
    do_op({$urandom, $urandom, $urandom, $urandom}, FKEY, {$urandom, $urandom, $urandom, $urandom}, 0, 3, 0, wr, kw, sw);
    send(FPT, FKEY);
    n = 0;
    while (!(bus.wb_stb_o && bus.wb_adr_o == BA + 32'hC) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_pt3", bus.wb_stb_o && bus.wb_adr_o == BA + 32'hC, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_bus", {bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_we_o, bus.wb_stb_o, bus.wb_cyc_o}, 71'd0);
    chk("midrst_req_ready", bus.req_ready, 1'b1);
    m_cvld = 0;
    seen = 0;
    repeat (40) begin
      if (bus.rsp_valid) seen = 1;
      @(negedge clk);
    end
    chk("midrst_no_rsp", seen, 1'b0);
    pk = FKEY;
    for (int i = 0; i < 8; i++) begin
      k = (i % 2 == 1) ? pk : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pk = k;
      do_op({$urandom, $urandom, $urandom, $urandom}, k, {$urandom, $urandom, $urandom, $urandom},
            int'($urandom_range(0, 6)), 0, int'($urandom_range(0, 3)), wr, kw, sw);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
